// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: Funct3 encodings, FSM states, access sizes.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  // Unlisted encodings (011, 110, 111) behave as full-word accesses.
  function automatic size_e decode_size(input logic [2:0] funct3);
    size_e sz;
    case (funct3)
      F3_B, F3_BU: sz = SZ_B;
      F3_H, F3_HU: sz = SZ_H;
      F3_W:        sz = SZ_W;
      default:     sz = SZ_W;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store byte mask and data replication, load extract and sign/zero extend.
// DMEM_MISALIGN_TRAP_EN enables misaligned detection; otherwise H/W offsets are forced aligned.
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [2:0]            funct3,
  input  logic [1:0]            addr_lo,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rword,
  output logic [DATA_WIDTH-1:0] wmask_c,
  output logic [DATA_WIDTH-1:0] wdata_c,
  output logic [DATA_WIDTH-1:0] rdata_c,
  output logic                  misaligned_c
);

  localparam int unsigned SH_W = $clog2(DATA_WIDTH);

  size_e                 size;
  logic [1:0]            off;
  logic [SH_W-1:0]       shamt;
  logic [DATA_WIDTH-1:0] word_sh;
  logic                  sgn;

  always_comb begin
    size         = decode_size(funct3);
    off          = addr_lo;
    misaligned_c = 1'b0;
    case (size)
      SZ_H:    off = {addr_lo[1], 1'b0};
      SZ_W:    off = 2'b00;
      default: off = addr_lo;
    endcase
`ifdef DMEM_MISALIGN_TRAP_EN
    misaligned_c = ((size == SZ_H) && addr_lo[0]) || ((size == SZ_W) && (addr_lo != 2'b00));
`endif
    shamt   = SH_W'({off, 3'b000});
    word_sh = rword >> shamt;
    sgn     = ~funct3[2];

    wmask_c = '1;
    wdata_c = wdata;
    rdata_c = rword;
    case (size)
      SZ_B: begin
        wmask_c = DATA_WIDTH'(8'hFF) << shamt;
        wdata_c = {(DATA_WIDTH/8){wdata[7:0]}};
        rdata_c = {{(DATA_WIDTH-8){sgn & word_sh[7]}}, word_sh[7:0]};
      end
      SZ_H: begin
        wmask_c = DATA_WIDTH'(16'hFFFF) << shamt;
        wdata_c = {(DATA_WIDTH/16){wdata[15:0]}};
        rdata_c = {{(DATA_WIDTH-16){sgn & word_sh[15]}}, word_sh[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-port data memory with a fixed-latency request/response handshake (IDLE -> WAIT -> RESP).
// Build option: DMEM_MISALIGN_TRAP_EN (see dmem_lane_align) reports misaligned H/W accesses.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  Req,
  input  logic                  MemRW,
  input  logic [2:0]            Funct3,
  input  logic [DATA_WIDTH-1:0] Addr,
  input  logic [DATA_WIDTH-1:0] WData,
  output logic                  Busy,
  output logic                  Ready,
  output logic [DATA_WIDTH-1:0] RData,
  output logic                  Misaligned
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  accept;

  logic                  rw_q;
  logic [2:0]            f3_q;
  logic [IDX_W+1:0]      addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic                  cur_rw;
  logic [2:0]            cur_f3;
  logic [IDX_W+1:0]      cur_addr;
  logic [DATA_WIDTH-1:0] cur_wdata;
  logic [IDX_W-1:0]      cur_idx;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rword;
  logic [DATA_WIDTH-1:0] wmask_c, wrep_c, ld_c, rdata_d;
  logic                  mis_c;
  logic                  unused_addr_hi;

  // Upper address bits alias onto the array (modulo DEPTH).
  assign unused_addr_hi = ^Addr[DATA_WIDTH-1:IDX_W+2];

  // In IDLE the live request is used so a zero-wait access can respond on the next cycle.
  always_comb begin
    cur_rw    = rw_q;
    cur_f3    = f3_q;
    cur_addr  = addr_q;
    cur_wdata = wdata_q;
    if (state_q == IDLE) begin
      cur_rw    = MemRW;
      cur_f3    = Funct3;
      cur_addr  = Addr[IDX_W+1:0];
      cur_wdata = WData;
    end
  end

  assign cur_idx = cur_addr[IDX_W+1:2];
  assign rword   = mem[cur_idx];

  dmem_lane_align #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_lane (
    .funct3      (cur_f3),
    .addr_lo     (cur_addr[1:0]),
    .wdata       (cur_wdata),
    .rword       (rword),
    .wmask_c     (wmask_c),
    .wdata_c     (wrep_c),
    .rdata_c     (ld_c),
    .misaligned_c(mis_c)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (Req) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(WAIT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    rdata_d = (!cur_rw && !mis_c) ? ld_c : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      Busy       <= 1'b0;
      Ready      <= 1'b0;
      Misaligned <= 1'b0;
      RData      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      Busy       <= (state_d != IDLE);
      Ready      <= (state_d == RESP);
      Misaligned <= (state_d == RESP) && mis_c;
      RData      <= (state_d == RESP) ? rdata_d : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      rw_q    <= MemRW;
      f3_q    <= Funct3;
      addr_q  <= Addr[IDX_W+1:0];
      wdata_q <= WData;
    end
  end

  // Store commits at the end of RESP so a reset during RESP still cancels it.
  always_ff @(posedge clk) begin
    if (rst_n && (state_q == RESP) && rw_q && !mis_c) begin
      mem[cur_idx] <= (rword & ~wmask_c) | (wrep_c & wmask_c);
    end
  end

endmodule
